// File: rtl/hbridge_supervisor.sv
// H-bridge start-up, protection and restart sequencer. Sits between the controller's gate
// requests and the gate drivers; every output is registered.
module hbridge_supervisor #(
   parameter int unsigned N_LEG     = 2,
   parameter int unsigned N_BIT_V   = 8,
   parameter int unsigned T_BOOT    = 1000,
   parameter int unsigned T_PRE     = 400,
   parameter int unsigned T_RETRY   = 100000,
   parameter int unsigned RETRY_MAX = 3,
   parameter int unsigned V_OV      = 50
) (
   input  logic                 i_CLK,
   input  logic                 i_RST,
   input  logic                 i_enable,
   input  logic [2*N_LEG-1:0]   i_Q,
   input  logic [N_BIT_V-1:0]   i_Vbat,
   input  logic                 i_fault_ext,
   output logic [2*N_LEG-1:0]   o_Q,
   output logic                 o_ctrl_rst,
   output logic                 o_on,
   output logic [2:0]           o_state,
   output logic [1:0]           o_retry_cnt
);

   localparam int unsigned T_MAX_BP = (T_BOOT > T_PRE) ? T_BOOT : T_PRE;
   localparam int unsigned T_MAX    = (T_MAX_BP > T_RETRY) ? T_MAX_BP : T_RETRY;
   localparam int unsigned TW       = (T_MAX > 1) ? $clog2(T_MAX) : 1;

   localparam logic [TW-1:0] BOOT_END  = TW'(T_BOOT - 1);
   localparam logic [TW-1:0] PRE_END   = TW'(T_PRE - 1);
   localparam logic [TW-1:0] RETRY_END = TW'(T_RETRY - 1);
   localparam logic [TW-1:0] TIMER_MAX = '1;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StBoot  = 3'd1,
      StPre   = 3'd2,
      StRun   = 3'd3,
      StFault = 3'd4,
      StLock  = 3'd5
   } state_e;

   state_e            state_q;
   logic [TW-1:0]     timer_q;
   logic [2*N_LEG-1:0] boot_pat;
   logic [2*N_LEG-1:0] pre_pat;
   logic [2*N_LEG-1:0] run_q;
   logic              shoot;
   logic              ovf;

   assign ovf     = (i_Vbat > N_BIT_V'(V_OV)) | i_fault_ext;
   assign o_state = state_q;

   // Legs are numbered from 1: odd legs get the low side, even legs the high side in PRE.
   always_comb begin
      boot_pat = '0;
      pre_pat  = '0;
      shoot    = 1'b0;
      for (int k = 0; k < N_LEG; k++) begin
         boot_pat[2*k+1] = 1'b1;
         if (k % 2 == 0) pre_pat[2*k+1] = 1'b1;
         else            pre_pat[2*k]   = 1'b1;
         shoot = shoot | (i_Q[2*k] & i_Q[2*k+1]);
      end
   end

   assign run_q = shoot ? '0 : i_Q;

   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         state_q     <= StIdle;
         timer_q     <= '0;
         o_Q         <= '0;
         o_ctrl_rst  <= 1'b0;
         o_on        <= 1'b0;
         o_retry_cnt <= '0;
      end else begin
         o_Q        <= '0;
         o_ctrl_rst <= 1'b0;
         o_on       <= 1'b0;
         timer_q    <= (timer_q == TIMER_MAX) ? timer_q : timer_q + 1'b1;
         if (!i_enable) begin
            state_q     <= StIdle;
            timer_q     <= '0;
            o_retry_cnt <= '0;
         end else begin
            unique case (state_q)
               StIdle: begin
                  state_q     <= StBoot;
                  timer_q     <= '0;
                  o_retry_cnt <= '0;
                  o_Q         <= boot_pat;
               end
               StBoot: begin
                  if (ovf) begin
                     state_q <= StFault;
                     timer_q <= '0;
                  end else if (timer_q == BOOT_END) begin
                     state_q <= StPre;
                     timer_q <= '0;
                     o_Q     <= pre_pat;
                  end else begin
                     o_Q <= boot_pat;
                  end
               end
               StPre: begin
                  if (ovf) begin
                     state_q <= StFault;
                     timer_q <= '0;
                  end else if (timer_q == PRE_END) begin
                     state_q    <= StRun;
                     timer_q    <= '0;
                     o_ctrl_rst <= 1'b1;
                     o_on       <= 1'b1;
                     o_Q        <= run_q;
                  end else begin
                     o_Q <= pre_pat;
                  end
               end
               StRun: begin
                  if (ovf) begin
                     state_q <= StFault;
                     timer_q <= '0;
                  end else begin
                     o_on <= 1'b1;
                     o_Q  <= run_q;
                  end
               end
               StFault: begin
                  if (timer_q == RETRY_END) begin
                     timer_q <= '0;
                     if (32'(o_retry_cnt) < RETRY_MAX) begin
                        state_q     <= StBoot;
                        o_retry_cnt <= o_retry_cnt + 1'b1;
                        o_Q         <= boot_pat;
                     end else begin
                        state_q <= StLock;
                     end
                  end
               end
               StLock: ;
               default: begin
                  state_q <= StIdle;
                  timer_q <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/hbridge_supervisor.md
Name: hbridge_supervisor

Overview:
- Start-up, protection and restart sequencer between the hybrid controller's gate requests and the H-bridge gate drivers.
- Replaces the fixed bootstrap counter, over-voltage gate and shoot-through mask with one parametrised FSM.
- Supports N_LEG half-bridge legs, programmable boot and precharge times, and bounded automatic retry after an over-voltage fault.
- Issues a one-cycle controller reset pulse each time the RUN state is entered.

Parameters:
- N_LEG, 2, number of half-bridge legs; gate bus width is 2*N_LEG.
- N_BIT_V, 8, width of the measured output voltage (volts, unsigned).
- T_BOOT, 1000, clock cycles with all low sides on (bootstrap charge).
- T_PRE, 400, clock cycles of the forced precharge pattern.
- T_RETRY, 100000, clock cycles spent in FAULT before a retry.
- RETRY_MAX, 3, automatic retries allowed before LOCK.
- V_OV, 50, over-voltage threshold; fault when i_Vbat > V_OV.

Ports:
- i_CLK  in  1  system clock (100 MHz domain).
- i_RST  in  1  reset; synchronous, active-high.
- i_enable  in  1  converter enable (debounced switch).
- i_Q  in  2*N_LEG  controller gate requests; bit 2k = leg k high side, bit 2k+1 = leg k low side.
- i_Vbat  in  N_BIT_V  measured output voltage.
- i_fault_ext  in  1  external fault (over-current etc.); immediate trip.
- o_Q  out  2*N_LEG  gate commands to dead-time/driver stage.
- o_ctrl_rst  out  1  one-cycle active-high pulse to reset the controller.
- o_on  out  1  high while in RUN.
- o_state  out  3  IDLE=0, BOOT=1, PRE=2, RUN=3, FAULT=4, LOCK=5.
- o_retry_cnt  out  2  retries consumed since the last IDLE.

Behaviour:
- All outputs are registered.
- i_RST: state=IDLE, o_Q=0, o_ctrl_rst=0, o_on=0, o_retry_cnt=0, timer=0. Reset mid-operation forces gates off on the next edge.
- OVF = (i_Vbat > V_OV) | i_fault_ext, sampled each cycle.
- IDLE:
  - o_Q=0.
  - i_enable=1 -> BOOT; timer cleared; o_retry_cnt cleared.
- BOOT:
  - o_Q = all low sides on, all high sides off.
  - When timer reaches T_BOOT-1 -> PRE.
- PRE:
  - o_Q: even legs high side on, odd legs low side on (forced sigma=1 pattern).
  - When timer reaches T_PRE-1 -> RUN, with o_ctrl_rst=1 for exactly that transition cycle.
- RUN:
  - o_Q <= i_Q with one cycle of latency.
  - If any leg requests high and low together, o_Q=0 for that cycle (whole-bus mask). This is not a fault; state is unchanged.
- FAULT:
  - o_Q=0.
  - After T_RETRY cycles: if o_retry_cnt < RETRY_MAX, increment o_retry_cnt and go to BOOT; otherwise go to LOCK.
- LOCK:
  - o_Q=0; exits only via i_enable=0 -> IDLE.
- Enable drop: i_enable=0 in any state -> IDLE on the next edge, o_Q=0. This has priority over OVF.
- Fault trip: OVF=1 in BOOT, PRE or RUN -> FAULT. o_Q=0 from the same edge: the registered output is forced 0 in the transition cycle.
- Timer: counts from 0 on each state entry and saturates at its maximum. Width is clog2 of the largest of T_BOOT, T_PRE, T_RETRY.
- Simultaneous events at the PRE->RUN boundary: OVF wins; state goes to FAULT and no o_ctrl_rst pulse is issued.
- o_on = (state==RUN), registered together with the state.

Test Plan:
1. Nominal start: N_LEG=2, T_BOOT=10, T_PRE=4, i_enable rises with i_Vbat=0.
   - o_Q=4'b1010 for 10 cycles, then 4'b0110 for 4 cycles.
   - o_ctrl_rst pulses for 1 cycle; o_on=1; o_Q follows i_Q one cycle late.
2. Shoot-through mask in RUN: i_Q=4'b0011 -> o_Q=4'b0000 next cycle, state stays 3. Then i_Q=4'b1001 -> o_Q=4'b1001.
3. Over-voltage with recovery: in RUN, i_Vbat=51.
   - o_Q=0 and state=4 next cycle.
   - After T_RETRY cycles: state=1, o_retry_cnt=1.
   - i_Vbat=50 does not trip.
4. Retry exhaustion: RETRY_MAX=3, i_Vbat held at 60.
   - Three BOOT re-entries, then state=5 with o_Q=0.
   - i_enable=0 -> state=0, o_retry_cnt=0.
5. Priority:
   - i_fault_ext=1 on the last PRE cycle -> FAULT, no o_ctrl_rst pulse.
   - i_enable=0 with OVF=1 simultaneously -> IDLE.
6. Synchronous reset: i_RST=1 in RUN -> after the next edge state=0 and o_Q=0. An i_RST pulse between edges that never coincides with a clock edge has no effect.
